// File: rtl/cpu_ctrl_pkg.sv
// Shared control-unit definitions: sequencer opcodes, condition-bus indices
// and the default micro-address width.
package cpu_ctrl_pkg;

  localparam int ADDR_W_DEFAULT = 8;
  localparam int COND_W         = 9;

  typedef enum logic [2:0] {
    SEQ_NEXT     = 3'd0,
    SEQ_JUMP_IF  = 3'd1,
    SEQ_CALL_IF  = 3'd2,
    SEQ_RET      = 3'd3,
    SEQ_DISPATCH = 3'd4,
    SEQ_HALT     = 3'd5
  } seq_op_e;

  // Condition bus layout: [0] constant true, then flag / inverted-flag pairs.
  localparam logic [3:0] COND_TRUE = 4'd0;
  localparam logic [3:0] COND_Z    = 4'd1;
  localparam logic [3:0] COND_NZ   = 4'd2;
  localparam logic [3:0] COND_C    = 4'd3;
  localparam logic [3:0] COND_NC   = 4'd4;
  localparam logic [3:0] COND_N    = 4'd5;
  localparam logic [3:0] COND_NN   = 4'd6;
  localparam logic [3:0] COND_V    = 4'd7;
  localparam logic [3:0] COND_NV   = 4'd8;
  localparam logic [3:0] COND_MAX  = COND_NV;

  function automatic logic cond_sel_legal(input logic [3:0] sel);
    return sel <= COND_MAX;
  endfunction

endpackage

// File: rtl/micro_stack.sv
// Small LIFO for microcode return addresses. Only the stack pointer is reset;
// entry contents are left as they are.
module micro_stack #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] push_data,
  output logic [DATA_W-1:0] top,
  output logic              full,
  output logic              empty
);

  localparam int SP_W  = $clog2(DEPTH + 1);
  localparam int IDX_W = $clog2(DEPTH);

  logic [SP_W-1:0]   r_sp;
  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [IDX_W-1:0]  w_wr_idx;
  logic [IDX_W-1:0]  w_top_idx;
  logic              w_do_push;
  logic              w_do_pop;

  assign full      = (r_sp == SP_W'(DEPTH));
  assign empty     = (r_sp == '0);
  assign w_do_push = push && !full;
  assign w_do_pop  = pop && !empty;
  // DEPTH is a power of two, so truncating sp gives the slot index directly.
  assign w_wr_idx  = IDX_W'(r_sp);
  assign w_top_idx = IDX_W'(r_sp - SP_W'(1));
  assign top       = r_mem[w_top_idx];

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_sp <= '0;
    end else if (w_do_push) begin
      r_sp <= r_sp + SP_W'(1);
    end else if (w_do_pop) begin
      r_sp <= r_sp - SP_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[w_wr_idx] <= push_data;
    end
  end

endmodule

// File: rtl/micro_sequencer.sv
// Microprogram sequencer: selects a branch condition, computes the next
// micro-address and manages the call/return stack for the control store.
module micro_sequencer
  import cpu_ctrl_pkg::*;
#(
  parameter int                ADDR_W      = ADDR_W_DEFAULT,
  parameter int                STACK_DEPTH = 4,
  parameter logic [ADDR_W-1:0] RESET_ADDR  = '0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [COND_W-1:0] conditional_wires,
  input  logic [3:0]        cond_sel,
  input  logic [2:0]        seq_op,
  input  logic [ADDR_W-1:0] branch_addr,
  input  logic [ADDR_W-1:0] dispatch_addr,
  input  logic              stall,
  output logic [ADDR_W-1:0] upc,
  output logic              halted,
  output logic              cond_taken,
  output logic              seq_err
);

  logic [ADDR_W-1:0] r_upc;
  logic              r_halted;
  logic              r_seq_err;

  logic [ADDR_W-1:0] w_upc_next;
  logic [ADDR_W-1:0] w_upc_inc;
  logic [ADDR_W-1:0] w_stack_top;
  logic              w_halted_next;
  logic              w_err_next;
  logic              w_cond;
  logic              w_push;
  logic              w_pop;
  logic              w_stack_full;
  logic              w_stack_empty;
  logic              w_active;

  assign w_cond     = cond_sel_legal(cond_sel) ? conditional_wires[cond_sel] : 1'b0;
  assign w_upc_inc  = r_upc + ADDR_W'(1);
  assign w_active   = !r_halted && !stall;
  assign cond_taken = w_cond;

  micro_stack #(
    .DEPTH  (STACK_DEPTH),
    .DATA_W (ADDR_W)
  ) u_stack (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (w_push),
    .pop       (w_pop),
    .push_data (w_upc_inc),
    .top       (w_stack_top),
    .full      (w_stack_full),
    .empty     (w_stack_empty)
  );

  always_comb begin
    w_upc_next    = r_upc;
    w_halted_next = r_halted;
    w_err_next    = 1'b0;
    w_push        = 1'b0;
    w_pop         = 1'b0;
    if (w_active) begin
      w_err_next = !cond_sel_legal(cond_sel);
      case (seq_op)
        SEQ_NEXT:    w_upc_next = w_upc_inc;
        SEQ_JUMP_IF: w_upc_next = w_cond ? branch_addr : w_upc_inc;
        SEQ_CALL_IF: begin
          if (w_cond) begin
            // A full stack still takes the branch; the lost return is flagged.
            w_upc_next = branch_addr;
            w_push     = !w_stack_full;
            if (w_stack_full) w_err_next = 1'b1;
          end else begin
            w_upc_next = w_upc_inc;
          end
        end
        SEQ_RET: begin
          if (w_stack_empty) begin
            w_upc_next = RESET_ADDR;
            w_err_next = 1'b1;
          end else begin
            w_upc_next = w_stack_top;
            w_pop      = 1'b1;
          end
        end
        SEQ_DISPATCH: w_upc_next = dispatch_addr;
        SEQ_HALT:     w_halted_next = 1'b1;
        default: begin
          w_upc_next = w_upc_inc;
          w_err_next = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_upc     <= RESET_ADDR;
      r_halted  <= 1'b0;
      r_seq_err <= 1'b0;
    end else begin
      r_upc     <= w_upc_next;
      r_halted  <= w_halted_next;
      r_seq_err <= w_err_next;
    end
  end

  assign upc     = r_upc;
  assign halted  = r_halted;
  assign seq_err = r_seq_err;

endmodule

// File: tb/tb_micro_sequencer.sv
// Directed and randomized checks of micro_sequencer against a queue-based
// behavioural model of the next-address rules.
module tb_micro_sequencer;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [8:0] conditional_wires = 9'h001;
  logic [3:0] cond_sel = 4'd0;
  logic [2:0] seq_op = 3'd0;
  logic [7:0] branch_addr = 8'h00;
  logic [7:0] dispatch_addr = 8'h00;
  logic       stall = 1'b0;
  logic [7:0] upc;
  logic       halted;
  logic       cond_taken;
  logic       seq_err;

  micro_sequencer #(
    .ADDR_W      (8),
    .STACK_DEPTH (4),
    .RESET_ADDR  (8'h00)
  ) dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .conditional_wires (conditional_wires),
    .cond_sel          (cond_sel),
    .seq_op            (seq_op),
    .branch_addr       (branch_addr),
    .dispatch_addr     (dispatch_addr),
    .stall             (stall),
    .upc               (upc),
    .halted            (halted),
    .cond_taken        (cond_taken),
    .seq_err           (seq_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  logic [7:0] m_upc;
  logic       m_halted;
  logic       m_err;
  logic [7:0] m_stack[$];

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
    n_checks++;
    assert (obs === exp_v) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
  endtask

  function automatic logic [8:0] wires_of(input logic [3:0] fl);
    logic [8:0] w;
    w[0] = 1'b1;
    for (int k = 0; k < 4; k++) begin
      w[2*k+1] = fl[k];
      w[2*k+2] = ~fl[k];
    end
    return w;
  endfunction

  task automatic check_state(input string tag);
    check({tag, ".upc"}, upc, m_upc);
    check({tag, ".halted"}, {7'd0, halted}, {7'd0, m_halted});
    check({tag, ".seq_err"}, {7'd0, seq_err}, {7'd0, m_err});
  endtask

  task automatic do_reset(input int cycles, input logic st);
    reset_n = 1'b0;
    stall   = st;
    seq_op  = 3'd5;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk);
      #1;
      m_upc = 8'h00; m_halted = 1'b0; m_err = 1'b0;
      m_stack.delete();
      check_state("reset");
      $display("reset cycle %0d upc=%0h halted=%0b", i, upc, halted);
    end
    reset_n = 1'b1;
    stall   = 1'b0;
  endtask

  task automatic step(input string tag, input logic [2:0] op, input logic [3:0] cs,
                      input logic [7:0] br, input logic [7:0] da, input logic st,
                      input logic [3:0] fl);
    logic       cond;
    logic [7:0] inc;
    logic [8:0] w;
    seq_op = op; cond_sel = cs; branch_addr = br; dispatch_addr = da; stall = st;
    w = wires_of(fl);
    conditional_wires = w;
    #1;
    cond = (cs <= 4'd8) ? w[cs] : 1'b0;
    check({tag, ".cond"}, {7'd0, cond_taken}, {7'd0, cond});
    inc   = m_upc + 8'd1;
    m_err = 1'b0;
    if (!m_halted && !st) begin
      if (cs > 4'd8) m_err = 1'b1;
      case (op)
        3'd0: m_upc = inc;
        3'd1: m_upc = cond ? br : inc;
        3'd2: begin
          if (cond) begin
            if (m_stack.size() < 4) m_stack.push_back(inc);
            else m_err = 1'b1;
            m_upc = br;
          end else m_upc = inc;
        end
        3'd3: begin
          if (m_stack.size() > 0) m_upc = m_stack.pop_back();
          else begin m_upc = 8'h00; m_err = 1'b1; end
        end
        3'd4: m_upc = da;
        3'd5: m_halted = 1'b1;
        default: begin m_upc = inc; m_err = 1'b1; end
      endcase
    end
    @(posedge clk);
    #1;
    check_state(tag);
    $display("%s op=%0d cs=%0d br=%0h da=%0h st=%0b -> upc=%0h halted=%0b err=%0b",
             tag, op, cs, br, da, st, upc, halted, seq_err);
  endtask

  initial begin
    m_upc = 8'h00; m_halted = 1'b0; m_err = 1'b0;

    do_reset(2, 1'b0);
    for (int i = 0; i < 3; i++) step("next", 3'd0, 4'd0, 8'h00, 8'h00, 1'b0, 4'h0);
    step("disp_ff", 3'd4, 4'd0, 8'h00, 8'hFF, 1'b0, 4'h0);
    step("wrap", 3'd0, 4'd0, 8'h00, 8'h00, 1'b0, 4'h0);

    step("jmp_taken", 3'd1, 4'd1, 8'h40, 8'h00, 1'b0, 4'b0001);
    step("jmp_not", 3'd1, 4'd2, 8'h55, 8'h00, 1'b0, 4'b0001);

    step("disp_05", 3'd4, 4'd0, 8'h00, 8'h05, 1'b0, 4'h0);
    step("call", 3'd2, 4'd0, 8'h20, 8'h00, 1'b0, 4'h0);
    step("ret", 3'd3, 4'd0, 8'h00, 8'h00, 1'b0, 4'h0);

    for (int i = 0; i < 5; i++) step("nest_call", 3'd2, 4'd0, 8'h30 + 8'(i * 16), 8'h00, 1'b0, 4'h0);
    for (int i = 0; i < 5; i++) step("nest_ret", 3'd3, 4'd0, 8'h00, 8'h00, 1'b0, 4'h0);
    step("after_uf", 3'd0, 4'd0, 8'h00, 8'h00, 1'b0, 4'h0);

    step("bad_cs", 3'd1, 4'd12, 8'h77, 8'h00, 1'b0, 4'hF);
    step("bad_op", 3'd7, 4'd0, 8'h00, 8'h00, 1'b0, 4'h0);
    step("call_nt", 3'd2, 4'd3, 8'h66, 8'h00, 1'b0, 4'h0);

    for (int i = 0; i < 3; i++) step("stall", 3'd4, 4'd0, 8'h00, 8'h80, 1'b1, 4'h0);
    step("release", 3'd4, 4'd0, 8'h00, 8'h80, 1'b0, 4'h0);

    step("disp_10", 3'd4, 4'd0, 8'h00, 8'h10, 1'b0, 4'h0);
    step("halt", 3'd5, 4'd0, 8'h00, 8'h00, 1'b0, 4'h0);
    for (int i = 0; i < 10; i++)
      step("halted", 3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)),
           8'($urandom), 8'($urandom), 1'($urandom), 4'($urandom));
    do_reset(1, 1'b1);
    step("sp_clear", 3'd3, 4'd0, 8'h00, 8'h00, 1'b0, 4'h0);

    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 39) == 0 || (m_halted && $urandom_range(0, 3) == 0)) begin
        do_reset(1, 1'($urandom));
      end else begin
        logic [2:0] op;
        int r;
        r  = $urandom_range(0, 99);
        op = (r < 20) ? 3'd0 : (r < 38) ? 3'd1 : (r < 62) ? 3'd2 : (r < 84) ? 3'd3 :
             (r < 92) ? 3'd4 : (r < 95) ? 3'd5 : 3'($urandom_range(6, 7));
        step("rand", op, ($urandom_range(0, 9) == 0) ? 4'($urandom_range(9, 15))
                                                    : 4'($urandom_range(0, 8)),
             8'($urandom), 8'($urandom), ($urandom_range(0, 7) == 0), 4'($urandom));
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
